// File: rtl/key_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_pkg                                                                     |
// | Shared state encoding, default timing constants and index helpers for the   |
// | key auto-repeat arbiter.                                                    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package key_pkg;

    localparam int unsigned      C_CNT_W         = 32;
    localparam int unsigned      C_DEFAULT_NKEYS = 4;
    localparam logic [C_CNT_W-1:0] C_DEFAULT_DELAY = 32'd24_999_999;
    localparam logic [C_CNT_W-1:0] C_DEFAULT_RATE  = 32'd4_999_999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } state_e;

    // Index width that stays legal for a single-key build.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_rr_pick                                                                 |
// | Combinational round-robin picker: lowest requesting index at or after       |
// | (last+1) mod NKEYS, wrapping around.                                        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module key_rr_pick
    import key_pkg::*;
#(
    parameter int unsigned NKEYS = C_DEFAULT_NKEYS,
    parameter int unsigned IDX_W = idx_w(NKEYS)
) (
    input  logic [NKEYS-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_found,
    output logic [IDX_W-1:0] o_index
);

    logic [IDX_W-1:0] w_pos;
    int unsigned      w_base;

    // Scan from the farthest candidate toward the nearest so the nearest
    // requester overwrites any earlier hit.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_pos   = '0;
        w_base  = 32'(i_last);
        for (int off = int'(NKEYS); off >= 1; off--) begin
            w_pos = IDX_W'(wrap_add(w_base, off, NKEYS));
            if (i_req[w_pos]) begin
                o_found = 1'b1;
                o_index = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_repeat_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_repeat_arbiter                                                          |
// | Grants one held key round-robin and emits an initial action pulse followed  |
// | by timed auto-repeat pulses until the key is released.                      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module key_repeat_arbiter
    import key_pkg::*;
#(
    parameter int unsigned         NKEYS = C_DEFAULT_NKEYS,
    parameter logic [C_CNT_W-1:0]  DELAY = C_DEFAULT_DELAY,
    parameter logic [C_CNT_W-1:0]  RATE  = C_DEFAULT_RATE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_enable,
    input  logic [NKEYS-1:0]          i_keys,
    output logic [NKEYS-1:0]          o_out,
    output logic [idx_w(NKEYS)-1:0]   o_key_idx,
    output logic                      o_valid,
    output logic                      o_repeat,
    output logic                      o_busy
);

    localparam int unsigned      IDX_W      = idx_w(NKEYS);
    localparam logic [IDX_W-1:0] C_LAST_RST = IDX_W'(NKEYS - 1);

    state_e             r_state_q,  w_state_d;
    logic [C_CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic [IDX_W-1:0]   r_idx_q,    w_idx_d;
    logic [IDX_W-1:0]   r_last_q,   w_last_d;
    logic [NKEYS-1:0]   r_out_q,    w_out_d;
    logic               r_valid_q,  w_valid_d;
    logic               r_repeat_q, w_repeat_d;

    logic               w_found;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_owner_held;

    key_rr_pick #(
        .NKEYS (NKEYS),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (i_keys),
        .i_last  (r_last_q),
        .o_found (w_found),
        .o_index (w_pick_idx)
    );

    assign w_owner_held = i_keys[r_idx_q];

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_idx_d    = r_idx_q;
        w_last_d   = r_last_q;
        w_out_d    = '0;
        w_valid_d  = 1'b0;
        w_repeat_d = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (i_enable && w_found) begin
                    w_state_d           = HOLD;
                    w_idx_d             = w_pick_idx;
                    w_cnt_d             = DELAY;
                    w_out_d[w_pick_idx] = 1'b1;
                    w_valid_d           = 1'b1;
                end
            end
            HOLD, RPT: begin
                // Release wins over an expiring counter: no pulse on that edge.
                if (!i_enable || !w_owner_held) begin
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                    w_last_d  = r_idx_q;
                end else if (r_cnt_q == '0) begin
                    w_state_d        = RPT;
                    w_cnt_d          = RATE;
                    w_out_d[r_idx_q] = 1'b1;
                    w_valid_d        = 1'b1;
                    w_repeat_d       = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q - 32'd1;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= IDLE;
            r_cnt_q    <= '0;
            r_idx_q    <= '0;
            r_last_q   <= C_LAST_RST;
            r_out_q    <= '0;
            r_valid_q  <= 1'b0;
            r_repeat_q <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_idx_q    <= w_idx_d;
            r_last_q   <= w_last_d;
            r_out_q    <= w_out_d;
            r_valid_q  <= w_valid_d;
            r_repeat_q <= w_repeat_d;
        end
    end

    assign o_out     = r_out_q;
    assign o_key_idx = r_idx_q;
    assign o_valid   = r_valid_q;
    assign o_repeat  = r_repeat_q;
    assign o_busy    = (r_state_q == HOLD) || (r_state_q == RPT);

endmodule
`default_nettype wire

// File: tb/tb_key_repeat_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_key_repeat_arbiter                                                       |
// | Vector table, directed corner sequences and random traffic against a        |
// | schedule-based reference model.                                             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_key_repeat_arbiter;

    localparam int unsigned NKEYS = 4;
    localparam int unsigned DELAY = 4;
    localparam int unsigned RATE  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] keys = 4'h0;
    logic [3:0] out;
    logic [1:0] key_idx;
    logic       valid, rpt, busy;

    int n_checks = 0;
    int n_errors = 0;

    key_repeat_arbiter #(
        .NKEYS (NKEYS),
        .DELAY (32'(DELAY)),
        .RATE  (32'(RATE))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_enable  (enable),
        .i_keys    (keys),
        .o_out     (out),
        .o_key_idx (key_idx),
        .o_valid   (valid),
        .o_repeat  (rpt),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    // Reference model: owner plus the age of the grant; pulses fall on a
    // fixed arithmetic schedule measured from the initial press.
    int         m_owner = -1;
    int         m_last  = NKEYS - 1;
    int         m_idx   = 0;
    int         m_age   = 0;
    logic [3:0] m_out   = 4'h0;
    logic       m_valid = 1'b0;
    logic       m_rpt   = 1'b0;

    task automatic model_step();
        m_out   = 4'h0;
        m_valid = 1'b0;
        m_rpt   = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_last  = NKEYS - 1;
            m_idx   = 0;
        end else if (m_owner < 0) begin
            if (enable && keys != 4'h0) begin
                for (int k = 1; k <= int'(NKEYS); k++) begin
                    int c;
                    c = (m_last + k) % NKEYS;
                    if (keys[c] && m_owner < 0) m_owner = c;
                end
                m_idx          = m_owner;
                m_age          = 0;
                m_out[m_owner] = 1'b1;
                m_valid        = 1'b1;
            end
        end else if (!enable || !keys[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end else begin
            m_age++;
            if (m_age >= int'(DELAY) + 1 && (m_age - (int'(DELAY) + 1)) % (int'(RATE) + 1) == 0) begin
                m_out[m_owner] = 1'b1;
                m_valid        = 1'b1;
                m_rpt          = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [3:0] k);
        rst    = r;
        enable = e;
        keys   = k;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_out",   32'(out),     32'(m_out));
        check("model_valid", 32'(valid),   32'(m_valid));
        check("model_rpt",   32'(rpt),     32'(m_rpt));
        check("model_busy",  32'(busy),    32'(m_owner >= 0));
        check("model_idx",   32'(key_idx), 32'(m_idx));
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] keys;
        logic [3:0] out;
        logic       valid;
        logic       rpt;
        logic       busy;
        logic [1:0] idx;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic e, input logic [3:0] k,
                                input logic [3:0] o, input logic v, input logic p,
                                input logic b, input logic [1:0] i);
        vec_t t;
        t = '{rst: r, en: e, keys: k, out: o, valid: v, rpt: p, busy: b, idx: i};
        vecs.push_back(t);
    endfunction

    initial begin
        // Key 0 held: grant, then repeats 5, 8, 11 edges after the grant.
        add(1, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        add(0, 1, 4'h1, 4'h1, 1, 0, 1, 0);
        repeat (4) add(0, 1, 4'h1, 4'h0, 0, 0, 1, 0);
        for (int r = 0; r < 3; r++) begin
            add(0, 1, 4'h1, 4'h1, 1, 1, 1, 0);
            if (r < 2) repeat (2) add(0, 1, 4'h1, 4'h0, 0, 0, 1, 0);
        end
        add(0, 1, 4'h0, 4'h0, 0, 0, 0, 0);
        // Key 1 held three cycles: single pulse, busy drops on release edge.
        add(0, 1, 4'h2, 4'h2, 1, 0, 1, 1);
        repeat (2) add(0, 1, 4'h2, 4'h0, 0, 0, 1, 1);
        add(0, 1, 4'h0, 4'h0, 0, 0, 0, 1);
        // Key 3: release exactly when the counter expires in RPT.
        add(0, 1, 4'h8, 4'h8, 1, 0, 1, 3);
        repeat (4) add(0, 1, 4'h8, 4'h0, 0, 0, 1, 3);
        add(0, 1, 4'h8, 4'h8, 1, 1, 1, 3);
        repeat (2) add(0, 1, 4'h8, 4'h0, 0, 0, 1, 3);
        add(0, 1, 4'h0, 4'h0, 0, 0, 0, 3);

        foreach (vecs[n]) begin
            drive(vecs[n].rst, vecs[n].en, vecs[n].keys);
            tick();
            check($sformatf("vec%0d_out", n),   32'(out),     32'(vecs[n].out));
            check($sformatf("vec%0d_valid", n), 32'(valid),   32'(vecs[n].valid));
            check($sformatf("vec%0d_rpt", n),   32'(rpt),     32'(vecs[n].rpt));
            check($sformatf("vec%0d_busy", n),  32'(busy),    32'(vecs[n].busy));
            check($sformatf("vec%0d_idx", n),   32'(key_idx), 32'(vecs[n].idx));
        end

        // All keys held with release/re-press: grants rotate 0,1,2,3,0.
        drive(1, 1, 4'h0); tick();
        for (int r = 0; r < 5; r++) begin
            drive(0, 1, 4'hF); tick();
            check("rr_idx", 32'(key_idx), 32'(r % 4));
            check("rr_valid", 32'(valid), 32'd1);
            tick();
            drive(0, 1, 4'h0); tick();
        end

        // A second key during ownership is ignored; granted after one idle cycle.
        drive(1, 1, 4'h0); tick();
        drive(0, 1, 4'h1); tick();
        drive(0, 1, 4'h5);
        repeat (3) begin
            tick();
            check("steal_out2", 32'(out[2]), 32'd0);
        end
        drive(0, 1, 4'h4); tick();
        check("steal_idle_busy", 32'(busy), 32'd0);
        check("steal_idle_valid", 32'(valid), 32'd0);
        tick();
        check("steal_grant_out", 32'(out), 32'h4);
        check("steal_grant_idx", 32'(key_idx), 32'd2);

        // Reset in RPT aborts, disabled arbiter stays quiet, then key 2 wins.
        drive(1, 1, 4'h0); tick();
        drive(0, 1, 4'h1);
        repeat (6) tick();
        check("rpt_reached", 32'(rpt), 32'd1);
        drive(1, 0, 4'h4); tick();
        check("rst_out", 32'(out), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_idx", 32'(key_idx), 32'd0);
        drive(0, 0, 4'h4);
        repeat (3) begin
            tick();
            check("dis_valid", 32'(valid), 32'd0);
        end
        drive(0, 1, 4'h4); tick();
        check("post_rst_out", 32'(out), 32'h4);
        check("post_rst_idx", 32'(key_idx), 32'd2);
        check("post_rst_rpt", 32'(rpt), 32'd0);

        // Random traffic: long holds so repeats occur, rare disables and resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) keys = 4'($urandom_range(0, 15));
            enable = ($urandom_range(0, 31) != 0);
            rst    = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_repeat_arbiter.md
KEY_REPEAT_ARBITER -- requirements
Module: key_repeat_arbiter

Interface
REQ-001 Parameter NKEYS, default 4, SHALL set the number of filtered key inputs.
REQ-002 Parameter DELAY, default 25_000_000-1, SHALL set the hold cycles before first auto-repeat (0.5 s at 50 MHz).
REQ-003 Parameter RATE, default 5_000_000-1, SHALL set the cycles between auto-repeats (10 per second at 50 MHz).
REQ-004 Clock  input  1  SHALL be the single system clock; all logic is on the posedge.
REQ-005 Reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 Enable  input  1  SHALL gate new grants; when low, the arbiter releases ownership and issues no pulses.
REQ-007 Keys  input  NKEYS  SHALL carry synchronized, debounced active-high key levels.
REQ-008 Out  output  NKEYS  SHALL be a one-hot, one-cycle action pulse for the owning key.
REQ-009 KeyIdx  output  $clog2(NKEYS)  SHALL hold the index of the current or last owner.
REQ-010 Valid  output  1  SHALL pulse for one cycle coincident with every Out pulse.
REQ-011 Repeat  output  1  SHALL pulse with Valid only for auto-repeat pulses, not the initial press.
REQ-012 Busy  output  1  SHALL be high while a key owns the arbiter (state HOLD or RPT).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, HOLD, RPT.
REQ-014 IDLE: with Enable=1 and any Keys bit high at an edge, the FSM SHALL grant one key round-robin, starting after the last granted index, and go to HOLD.
REQ-015 The grant edge SHALL register Out=one-hot(owner), Valid=1, Repeat=0, KeyIdx=owner, counter=DELAY; latency is one cycle from sampled press to pulse.
REQ-016 HOLD/RPT: if Keys[owner]=0 or Enable=0 at an edge, the FSM SHALL go to IDLE, clear the counter, issue no pulse, and record owner as last granted.
REQ-017 HOLD/RPT: otherwise, at counter=0, the FSM SHALL issue Out/Valid/Repeat=1, reload counter=RATE, and enter or stay in RPT; at counter>0, it SHALL decrement.
REQ-018 First repeat SHALL occur DELAY+1 cycles after the initial pulse; later repeats SHALL occur every RATE+1 cycles.
REQ-019 Release on the same edge the counter reaches 0 SHALL take priority: no pulse, go to IDLE.
REQ-020 Other keys pressed while a key owns the arbiter SHALL be ignored until IDLE is re-entered; there is no queueing.
REQ-021 A re-grant SHALL occur no earlier than the edge after the return to IDLE, so IDLE lasts at least one cycle.
REQ-022 With several keys high in IDLE, the lowest index at or after (last+1) mod NKEYS SHALL win, wrapping around.
REQ-023 The counter SHALL be 32 bits unsigned; DELAY and RATE SHALL be less than 2^32.
REQ-024 Out, Valid and Repeat SHALL default to 0 on every cycle they are not explicitly pulsed.

Reset
REQ-025 Reset=1 at an edge SHALL force IDLE, counter=0, Out=0, Valid=0, Repeat=0, Busy=0, KeyIdx=0, and last granted=NKEYS-1 (key 0 has first priority).
REQ-026 Reset mid-HOLD/RPT SHALL abort ownership with no pulse on that edge; Reset SHALL dominate Enable and Keys.

Structure
REQ-027 Package key_pkg SHALL hold the state enum (IDLE, HOLD, RPT), the default NKEYS/DELAY/RATE constants, and the counter width.
REQ-028 The round-robin picker SHALL be a combinational sub-module key_rr_pick (inputs: request vector, last index; outputs: found, index).

Verification (NKEYS=4, DELAY=4, RATE=2)
REQ-029 Keys=0001 from cycle 0, held -> Out=0001 Valid=1 Repeat=0 at cycle 1; Repeat pulses at cycles 6, 9, 12.
REQ-030 Keys=0010 held 3 cycles then released -> single pulse with KeyIdx=1, no Repeat, Busy falls the edge after release.
REQ-031 Keys=1111 held, released and re-pressed 4 times -> grants in order 0, 1, 2, 3, then wrap to 0.
REQ-032 Key 0 owns, Keys 2 asserted during HOLD -> no Out[2]; after key 0 is released, key 2 is granted at least one IDLE cycle later.
REQ-033 Release coincident with counter=0 in RPT -> no pulse that cycle, state IDLE.
REQ-034 Reset asserted in RPT and Enable=0 with Keys=0100 -> outputs zero, no pulses; after Enable=1, the first grant goes to key 2, with last granted reset to 3.
